// File: rtl/dmem_lsu.sv
// Load/store unit: CPU byte-addressed requests -> word-addressed RAM with byte enables, aligned/extended reads.
// Latency: store or rejected access responds 1 cycle after accept, load responds 2 cycles after accept.
// Backpressure: one request in flight; req_ready low until the response handshakes, response held until rsp_ready.
module dmem_lsu #(
    parameter int          DEPTH     = 28672,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wenable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_unsigned;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;

    logic [31:0] w_offset;
    logic [31:0] w_word_idx;
    logic [1:0]  w_lane;
    logic        w_err;
    logic        w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    // Address translation is purely combinational so the RAM sees the index in the accept cycle.
    assign w_offset   = req_addr - BASE_ADDR;
    assign w_word_idx = {2'b00, w_offset[31:2]};
    assign w_lane     = w_offset[1:0];
    assign mem_addr   = w_word_idx;

    assign w_err = (req_size == 2'd3)
                 | ((req_size == 2'd1) && w_lane[0])
                 | ((req_size == 2'd2) && (w_lane != 2'd0))
                 | (req_addr < BASE_ADDR)
                 | (w_word_idx >= DEPTH_W);

    assign w_accept  = req_valid && (r_state == IDLE);
    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

    // Byte enables and lane-replicated write data; enables only fire for an accepted, legal store.
    always_comb begin
        w_be      = 4'b1111;
        mem_wdata = req_wdata;
        case (req_size)
            2'd0: begin
                w_be      = 4'b0001 << w_lane;
                mem_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_be      = 4'b0011 << w_lane;
                mem_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                mem_wdata = req_wdata;
            end
        endcase
        mem_wenable = (w_accept && req_write && !w_err) ? w_be : 4'b0000;
    end

    // Shift the addressed lane down to bit 0, then sign- or zero-extend by the latched size.
    always_comb begin
        w_shifted   = mem_rdata >> {r_lane, 3'b000};
        w_load_data = mem_rdata;
        case (r_size)
            2'd0:    w_load_data = r_unsigned ? {24'h0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    w_load_data = r_unsigned ? {16'h0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next state: stores and rejected accesses skip the read wait.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = (w_err || req_write) ? RESP : RD_WAIT;
            end
            RD_WAIT: w_next = RESP;
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request context and response registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_size      <= 2'd0;
            r_lane      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_size      <= req_size;
                        r_lane      <= w_lane;
                        r_unsigned  <= req_unsigned;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_error <= w_err;
                    end
                end
                RD_WAIT: r_rsp_rdata <= w_load_data;
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_rdata <= 32'h0;
                        r_rsp_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

    localparam int          DEPTH = 28672;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wenable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    // Environment RAM (2-state, starts at zero) and byte-level reference memory.
    bit [31:0] ram     [0:32767];
    bit [7:0]  ref_mem [0:131071];

    dmem_lsu #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .mem_addr(mem_addr),
        .mem_wenable(mem_wenable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Word RAM with byte enables and a registered read.
    always @(posedge clock) begin
        if (mem_addr < 32'(DEPTH)) begin
            for (int b = 0; b < 4; b++)
                if (mem_wenable[b]) ram[mem_addr[14:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr[14:0]];
        end else begin
            mem_rdata <= 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and retire its response; starts and ends just after a falling edge.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, input bit early, output logic [31:0] o_rd);
        longint off;
        int     nb;
        bit     err;
        logic [3:0]  exp_wen;
        logic [31:0] exp_wd;
        longint      v;
        int          lat;
        int          n;

        off = longint'(addr) - longint'(BASE);
        nb  = (sz == 2'd3) ? 0 : (1 << sz);
        err = (sz == 2'd3) || (off < 0) || (off >= 4 * DEPTH) || ((off % nb) != 0);
        exp_wen = (wr && !err) ? 4'(((1 << nb) - 1) << (off % 4)) : 4'b0000;
        exp_wd  = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
        v = 0;
        if (!wr && !err) begin
            for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[int'(off) + i]) << (8 * i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((longint'(1) << (8 * nb)) - 1);
        end

        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        chk("req_ready_before_req", req_ready, 1);

        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; rsp_ready = early;
        #1;
        chk("mem_addr", mem_addr, (addr - BASE) >> 2);
        chk("mem_wenable_accept", mem_wenable, exp_wen);
        if (wr && !err) chk("mem_wdata", mem_wdata, exp_wd);
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_size = 2'($urandom); req_write = 1'($urandom);

        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            chk("mem_wenable_idle", mem_wenable, 0);
            if (!rsp_valid) chk("req_ready_busy", req_ready, 0);
        end while (!rsp_valid && lat < 10);
        chk("latency", lat, (wr || err) ? 1 : 2);
        chk("rsp_rdata", rsp_rdata, 32'(v));
        chk("rsp_error", rsp_error, err);
        o_rd = rsp_rdata;

        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clock);
                chk("hold_rsp_valid", rsp_valid, 1);
                chk("hold_rsp_rdata", rsp_rdata, 32'(v));
                chk("hold_req_ready", req_ready, 0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        @(negedge clock);
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_req_ready", req_ready, 1);

        if (wr && !err)
            for (int i = 0; i < nb; i++) ref_mem[int'(off) + i] = wd[8*i +: 8];
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [1:0]  s;

        // Reset state.
        repeat (3) @(negedge clock);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_error", rsp_error, 0);
        chk("reset_req_ready", req_ready, 1);
        resetn = 1'b1;
        @(negedge clock);

        // Word store/load.
        do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0, rd);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, 0, rd);
        chk("word_load_literal", rd, 32'hDEADBEEF);

        // Byte store at lane 3, signed and unsigned reload.
        do_req(1, 2'd0, 0, 32'h13, 32'h00000080, 0, 0, rd);
        do_req(0, 2'd0, 0, 32'h13, 32'h0, 0, 0, rd);
        chk("byte_signed_literal", rd, 32'hFFFFFF80);
        do_req(0, 2'd0, 1, 32'h13, 32'h0, 0, 0, rd);
        chk("byte_unsigned_literal", rd, 32'h00000080);

        // Half store at lane 2.
        do_req(1, 2'd1, 0, 32'h22, 32'h00008001, 0, 0, rd);
        do_req(0, 2'd1, 0, 32'h22, 32'h0, 0, 0, rd);
        chk("half_signed_literal", rd, 32'hFFFF8001);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 0, 0, rd);
        chk("half_word_literal", rd, 32'h80010000);

        // Rejected accesses, with readback showing memory untouched.
        do_req(1, 2'd2, 0, 32'h21, 32'h11111111, 0, 0, rd);
        do_req(1, 2'd1, 0, 32'h23, 32'h2222, 0, 0, rd);
        do_req(1, 2'd3, 0, 32'h20, 32'h33333333, 0, 0, rd);
        do_req(0, 2'd3, 0, 32'h20, 32'h0, 0, 0, rd);
        do_req(1, 2'd0, 0, 32'h0001C000, 32'h44, 0, 0, rd);
        do_req(0, 2'd0, 0, 32'h0001C000, 32'h0, 0, 0, rd);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 0, 0, rd);
        chk("err_readback_literal", rd, 32'h80010000);

        // Last legal byte.
        do_req(1, 2'd0, 0, 32'h0001BFFF, 32'h5A, 0, 0, rd);
        do_req(0, 2'd0, 1, 32'h0001BFFF, 32'h0, 0, 0, rd);
        chk("top_byte_literal", rd, 32'h0000005A);

        // Backpressure on a load, and early rsp_ready on another.
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 5, 0, rd);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, 1, rd);

        // Reset while waiting for read data.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clock);
        #1 req_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("midreset_rsp_valid", rsp_valid, 0);
        chk("midreset_rsp_rdata", rsp_rdata, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("after_reset_req_ready", req_ready, 1);
        chk("after_reset_rsp_valid", rsp_valid, 0);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, 0, rd);

        // Randomized traffic against the byte-level reference.
        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h0001BFF0 + $urandom_range(0, 31);
                1:       a = $urandom;
                default: a = $urandom_range(0, 255);
            endcase
            s = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(1'($urandom), s, 1'($urandom), a, $urandom,
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
